// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - Hazard, forwarding and pipeline-control unit for a 5-stage ARM pipeline
// Also keeps saturating hazard counters and a stall watchdog for debug.
module hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             CondExE,
  input  logic             BranchTakenE,
  input  logic             cnt_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             PCSrcW,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] ldr_cnt,
  output logic             hazard_timeout
);

  localparam int               RUN_W   = 8;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       pcw;
  logic             ldr_stall;
  logic             pc_wr_pending;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;

  // R15 reads are never forwarded: the PC value comes from the fetch path.
  always_comb begin
    fwd_a = 2'b00;
    if (RegWriteM && (RA1E == WA3M) && (RA1E != 4'd15))
      fwd_a = 2'b10;
    else if (RegWriteW && (RA1E == WA3W) && (RA1E != 4'd15))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (RegWriteM && (RA2E == WA3M) && (RA2E != 4'd15))
      fwd_b = 2'b10;
    else if (RegWriteW && (RA2E == WA3W) && (RA2E != 4'd15))
      fwd_b = 2'b01;
  end

  assign ldr_stall     = MemtoRegE && RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign pc_wr_pending = PCSrcD || pcw[0] || pcw[1];
  assign PCSrcW        = pcw[2];

  // While in reset the pipeline registers are held flushed and nothing forwards.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      StallF    = ldr_stall || pc_wr_pending;
      StallD    = ldr_stall;
      FlushD    = pc_wr_pending || PCSrcW || BranchTakenE;
      FlushE    = ldr_stall || BranchTakenE;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
    end
  end

  // A PC write squashed in ID/EX or failing its condition never reaches W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcw <= 3'b000;
    end else begin
      pcw[0] <= PCSrcD && !FlushE;
      pcw[1] <= pcw[0] && CondExE;
      pcw[2] <= pcw[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      ldr_cnt   <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      ldr_cnt   <= '0;
    end else begin
      if (StallF && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (FlushE && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (ldr_stall && (ldr_cnt != CNT_MAX))
        ldr_cnt <= ldr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    run_nxt = '0;
    if (StallF)
      run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
  end

  // Timeout is raised on the same edge that completes the MAX_STALL-th stalled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt        <= '0;
      hazard_timeout <= 1'b0;
    end else if (cnt_clr) begin
      run_cnt        <= '0;
      hazard_timeout <= 1'b0;
    end else begin
      run_cnt <= run_nxt;
      if (run_nxt == RUN_MAX)
        hazard_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - Directed self-checking bench for hazard_ctrl
// Counters are narrowed to 4 bits so saturation is reachable in a few cycles.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, CondExE, BranchTakenE, cnt_clr;
  logic       StallF, StallD, FlushD, FlushE, PCSrcW, hazard_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] stall_cnt, flush_cnt, ldr_cnt;

  int vectors;
  int miscompares;

  hazard_ctrl #(.CNT_W(4), .MAX_STALL(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .CondExE(CondExE),
    .BranchTakenE(BranchTakenE), .cnt_clr(cnt_clr),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .PCSrcW(PCSrcW),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .ldr_cnt(ldr_cnt),
    .hazard_timeout(hazard_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; CondExE = 1'b1; BranchTakenE = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic set_load_use();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
  endtask

  task automatic clear_load_use();
    MemtoRegE = 1'b0; RegWriteE = 1'b0; RA2D = 4'd0; RA1D = 4'd0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCSrcW} !== 9'b0011_0000_0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 001100000",
               {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCSrcW});
    end
    vectors++;
    if ({stall_cnt, flush_cnt, ldr_cnt, hazard_timeout} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_cnt got %h/%h/%h/%b want 0/0/0/0",
               stall_cnt, flush_cnt, ldr_cnt, hazard_timeout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({StallF, FlushD, FlushE, PCSrcW} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_release got %b want 0000", {StallF, FlushD, FlushE, PCSrcW});
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3;
    RA1E = 4'd3; RA2E = 4'd3;
    #1;
    vectors++;
    if ({ForwardAE, ForwardBE} !== 4'b1010) begin
      miscompares++;
      $display("FAIL fwd_m_priority got %b want 1010", {ForwardAE, ForwardBE});
    end
    RegWriteM = 1'b0;
    #1;
    vectors++;
    if ({ForwardAE, ForwardBE} !== 4'b0101) begin
      miscompares++;
      $display("FAIL fwd_w got %b want 0101", {ForwardAE, ForwardBE});
    end
    RegWriteM = 1'b1; WA3M = 4'd15; WA3W = 4'd15; RA1E = 4'd15; RA2E = 4'd7;
    #1;
    vectors++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      miscompares++;
      $display("FAIL fwd_r15 got %b want 0000", {ForwardAE, ForwardBE});
    end
    WA3W = 4'd7;
    #1;
    vectors++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) begin
      miscompares++;
      $display("FAIL fwd_b_only got %b want 0001", {ForwardAE, ForwardBE});
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    pulse_clear();
    set_load_use();
    #1;
    vectors++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
      miscompares++;
      $display("FAIL ldr_ctrl got %b want 1101", {StallF, StallD, FlushD, FlushE});
    end
    @(negedge clk);
    clear_load_use();
    #1;
    vectors++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      miscompares++;
      $display("FAIL ldr_release got %b want 000", {StallF, StallD, FlushE});
    end
    vectors++;
    if ({ldr_cnt, stall_cnt, flush_cnt} !== {4'd1, 4'd1, 4'd1}) begin
      miscompares++;
      $display("FAIL ldr_counts got %0d/%0d/%0d want 1/1/1", ldr_cnt, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_pc_write(input logic cond);
    logic [4:0] exp_sf, exp_fd, exp_pw;
    exp_sf = cond ? 5'b00111 : 5'b00011;
    exp_fd = cond ? 5'b01111 : 5'b00011;
    exp_pw = cond ? 5'b01000 : 5'b00000;
    @(negedge clk);
    CondExE = cond;
    PCSrcD  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        PCSrcD = 1'b0;
      end
      #1;
      vectors++;
      if ({StallF, FlushD, PCSrcW} !== {exp_sf[i], exp_fd[i], exp_pw[i]}) begin
        miscompares++;
        $display("FAIL pc_write cond=%b cyc=%0d got %b want %b", cond, i,
                 {StallF, FlushD, PCSrcW}, {exp_sf[i], exp_fd[i], exp_pw[i]});
      end
    end
    CondExE = 1'b1;
  endtask

  task automatic test_branch_beats_stall();
    pulse_clear();
    set_load_use();
    BranchTakenE = 1'b1;
    #1;
    vectors++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1111) begin
      miscompares++;
      $display("FAIL br_stall_ctrl got %b want 1111", {StallF, StallD, FlushD, FlushE});
    end
    @(negedge clk);
    clear_load_use();
    BranchTakenE = 1'b0;
    #1;
    vectors++;
    if ({flush_cnt, ldr_cnt} !== {4'd1, 4'd1}) begin
      miscompares++;
      $display("FAIL br_stall_cnt got %0d/%0d want 1/1", flush_cnt, ldr_cnt);
    end
  endtask

  task automatic test_watchdog();
    pulse_clear();
    set_load_use();
    repeat (7) @(negedge clk);
    clear_load_use();
    #1;
    vectors++;
    if (hazard_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_seven got %b want 0", hazard_timeout);
    end
    @(negedge clk);
    set_load_use();
    repeat (7) @(negedge clk);
    #1;
    vectors++;
    if (hazard_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_before_trip got %b want 0", hazard_timeout);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (hazard_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_trip got %b want 1", hazard_timeout);
    end
    vectors++;
    if (stall_cnt !== 4'd15) begin
      miscompares++;
      $display("FAIL wd_stall_cnt got %0d want 15", stall_cnt);
    end
    repeat (3) @(negedge clk);
    clear_load_use();
    #1;
    vectors++;
    if ({stall_cnt, ldr_cnt, flush_cnt} !== {4'd15, 4'd15, 4'd15}) begin
      miscompares++;
      $display("FAIL cnt_saturate got %0d/%0d/%0d want 15/15/15", stall_cnt, ldr_cnt, flush_cnt);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (hazard_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_sticky got %b want 1", hazard_timeout);
    end
    set_load_use();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    vectors++;
    if ({stall_cnt, flush_cnt, ldr_cnt, hazard_timeout} !== 13'd0) begin
      miscompares++;
      $display("FAIL cnt_clr got %0d/%0d/%0d/%b want 0/0/0/0",
               stall_cnt, flush_cnt, ldr_cnt, hazard_timeout);
    end
    clear_load_use();
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    PCSrcD = 1'b1;
    @(negedge clk);
    PCSrcD = 1'b0;
    set_load_use();
    RegWriteM = 1'b1; WA3M = 4'd2; RA1E = 4'd2; RA2E = 4'd2;
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE} !== 8'b0011_0000) begin
      miscompares++;
      $display("FAIL reset_mid got %b want 00110000",
               {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE});
    end
    vectors++;
    if ({stall_cnt, hazard_timeout, PCSrcW} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_mid_state got %0d/%b/%b want 0/0/0", stall_cnt, hazard_timeout, PCSrcW);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if ({StallF, FlushD, PCSrcW} !== 3'b000) begin
        miscompares++;
        $display("FAIL no_phantom cyc=%0d got %b want 000", i, {StallF, FlushD, PCSrcW});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_pc_write(1'b1);
    test_pc_write(1'b0);
    test_branch_beats_stall();
    test_watchdog();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
